// File: rtl/cpu_fetch_sequencer.sv
// 6502 instruction-fetch front end: reset-vector load, opcode/operand fetch, bundle handshake.
// Optional IRQ bundle injection is enabled by defining FETCH_IRQ_INJECT_EN.
module cpu_fetch_sequencer #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(16'hFFFC)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              rdy,
   input  logic [DATA_W-1:0] bus_data_in,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_rnw,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_opcode,
   output logic [DATA_W-1:0] instr_op1,
   output logic [DATA_W-1:0] instr_op2,
   output logic [1:0]        instr_len,
   output logic [ADDR_W-1:0] instr_pc,
`ifdef FETCH_IRQ_INJECT_EN
   input  logic              irq_n,
   input  logic              irq_mask,
   output logic              instr_irq,
`endif
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   typedef enum logic [2:0] {
      RST_LO = 3'd0,
      RST_HI = 3'd1,
      OPC    = 3'd2,
      OP1    = 3'd3,
      OP2    = 3'd4,
      HOLD   = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] opcode_q, opcode_d;
   logic [DATA_W-1:0] op1_q, op1_d;
   logic [DATA_W-1:0] op2_q, op2_d;
   logic [1:0]        len_q, len_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;
   logic              irq_q, irq_d;
   logic              irq_take_c;
   logic [1:0]        dec_len_c;
   logic [ADDR_W-1:0] pc_inc_c;

   // Instruction length from the aaabbbcc opcode fields
   function automatic logic [1:0] decode_len(input logic [7:0] op);
      logic [2:0] aaa;
      logic [2:0] bbb;
      logic [1:0] cc;
      aaa = op[7:5];
      bbb = op[4:2];
      cc  = op[1:0];
      decode_len = 2'd1;
      case (cc)
         2'b01: begin
            if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) decode_len = 2'd3;
            else                                                  decode_len = 2'd2;
         end
         2'b10: begin
            if (bbb == 3'b011 || bbb == 3'b111)      decode_len = 2'd3;
            else if (bbb == 3'b010 || bbb == 3'b110) decode_len = 2'd1;
            else                                     decode_len = 2'd2;
         end
         2'b00: begin
            if (bbb == 3'b011 || bbb == 3'b111 || op == 8'h20)           decode_len = 2'd3;
            else if (bbb == 3'b001 || bbb == 3'b100 || bbb == 3'b101)    decode_len = 2'd2;
            else if (bbb == 3'b000 && aaa >= 3'b101)                     decode_len = 2'd2;
            else                                                         decode_len = 2'd1;
         end
         default: decode_len = 2'd1;
      endcase
   endfunction

   assign dec_len_c = decode_len(bus_data_in[7:0]);
   assign pc_inc_c  = pc_q + ADDR_W'(1);

`ifdef FETCH_IRQ_INJECT_EN
   assign irq_take_c = ~irq_n & ~irq_mask;
`else
   assign irq_take_c = 1'b0;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      addr_d   = addr_q;
      valid_d  = valid_q;
      opcode_d = opcode_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      len_d    = len_q;
      ipc_d    = ipc_q;
      irq_d    = irq_q;

      case (state_q)
         RST_LO: begin
            if (rdy) begin
               pc_d    = ADDR_W'(bus_data_in);
               addr_d  = RESET_VECTOR + ADDR_W'(1);
               state_d = RST_HI;
            end
         end
         RST_HI: begin
            if (rdy) begin
               pc_d    = ADDR_W'({bus_data_in, pc_q[DATA_W-1:0]});
               addr_d  = ADDR_W'({bus_data_in, pc_q[DATA_W-1:0]});
               state_d = OPC;
            end
         end
         OPC: begin
            if (rdy) begin
               op1_d = '0;
               op2_d = '0;
               ipc_d = pc_q;
               if (irq_take_c) begin
                  // Injected BRK-style bundle: no bus read, PC stays put
                  opcode_d = '0;
                  len_d    = 2'd1;
                  irq_d    = 1'b1;
                  valid_d  = 1'b1;
                  state_d  = HOLD;
               end else begin
                  opcode_d = bus_data_in;
                  len_d    = dec_len_c;
                  irq_d    = 1'b0;
                  pc_d     = pc_inc_c;
                  addr_d   = pc_inc_c;
                  if (dec_len_c == 2'd1) begin
                     valid_d = 1'b1;
                     state_d = HOLD;
                  end else begin
                     state_d = OP1;
                  end
               end
            end
         end
         OP1: begin
            if (rdy) begin
               op1_d  = bus_data_in;
               pc_d   = pc_inc_c;
               addr_d = pc_inc_c;
               if (len_q == 2'd2) begin
                  valid_d = 1'b1;
                  state_d = HOLD;
               end else begin
                  state_d = OP2;
               end
            end
         end
         OP2: begin
            if (rdy) begin
               op2_d   = bus_data_in;
               pc_d    = pc_inc_c;
               addr_d  = pc_inc_c;
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (instr_ready) begin
               valid_d = 1'b0;
               state_d = OPC;
            end
         end
         default: state_d = RST_LO;
      endcase

      // Redirect overrides handshake and stall once out of the reset-vector load
      if (redirect_valid && state_q != RST_LO && state_q != RST_HI) begin
         pc_d    = redirect_pc;
         addr_d  = redirect_pc;
         valid_d = 1'b0;
         state_d = OPC;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= RST_LO;
         pc_q     <= '0;
         addr_q   <= RESET_VECTOR;
         valid_q  <= 1'b0;
         opcode_q <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         len_q    <= '0;
         ipc_q    <= '0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         valid_q  <= valid_d;
         opcode_q <= opcode_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         len_q    <= len_d;
         ipc_q    <= ipc_d;
         irq_q    <= irq_d;
      end
   end

   assign bus_addr     = addr_q;
   assign bus_rnw      = 1'b1;
   assign instr_valid  = valid_q;
   assign instr_opcode = opcode_q;
   assign instr_op1    = op1_q;
   assign instr_op2    = op2_q;
   assign instr_len    = len_q;
   assign instr_pc     = ipc_q;
`ifdef FETCH_IRQ_INJECT_EN
   assign instr_irq    = irq_q;
`else
   logic unused_irq;
   assign unused_irq = irq_q;
`endif

endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// Directed self-checking bench for cpu_fetch_sequencer with a flat 64 KiB memory model.
module tb_cpu_fetch_sequencer;

   logic        clk;
   logic        nrst;
   logic        rdy;
   logic [7:0]  bus_data_in;
   logic [15:0] bus_addr;
   logic        bus_rnw;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  instr_opcode;
   logic [7:0]  instr_op1;
   logic [7:0]  instr_op2;
   logic [1:0]  instr_len;
   logic [15:0] instr_pc;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
`ifdef FETCH_IRQ_INJECT_EN
   logic        irq_n;
   logic        irq_mask;
   logic        instr_irq;
`endif

   logic [7:0]  mem [0:65535];
   int          n_cmp;
   int          n_err;

   cpu_fetch_sequencer dut (
      .clk            (clk),
      .nrst           (nrst),
      .rdy            (rdy),
      .bus_data_in    (bus_data_in),
      .bus_addr       (bus_addr),
      .bus_rnw        (bus_rnw),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_opcode   (instr_opcode),
      .instr_op1      (instr_op1),
      .instr_op2      (instr_op2),
      .instr_len      (instr_len),
      .instr_pc       (instr_pc),
`ifdef FETCH_IRQ_INJECT_EN
      .irq_n          (irq_n),
      .irq_mask       (irq_mask),
      .instr_irq      (instr_irq),
`endif
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   assign bus_data_in = mem[bus_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the DUT in OPC; waits (bounded) for the bundle and checks it
   task automatic wait_bundle(input string tag, input int exp_cyc, input logic [7:0] op,
                              input logic [7:0] o1, input logic [7:0] o2,
                              input logic [1:0] len, input logic [15:0] pc);
      int cyc;
      cyc = 0;
      while (!instr_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, ".latency"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, ".valid"},   32'(instr_valid),  32'd1);
      chk({tag, ".opcode"},  32'(instr_opcode), 32'(op));
      chk({tag, ".op1"},     32'(instr_op1),    32'(o1));
      chk({tag, ".op2"},     32'(instr_op2),    32'(o2));
      chk({tag, ".len"},     32'(instr_len),    32'(len));
      chk({tag, ".pc"},      32'(instr_pc),     32'(pc));
   endtask

   task automatic accept(input string tag);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      chk({tag, ".drop"}, 32'(instr_valid), 32'd0);
   endtask

   logic [7:0]  dec_op  [6] = '{8'h20, 8'hA0, 8'h60, 8'h10, 8'h0A, 8'hFF};
   logic [7:0]  dec_o1  [6] = '{8'h11, 8'h33, 8'h00, 8'h44, 8'h00, 8'h00};
   logic [7:0]  dec_o2  [6] = '{8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [1:0]  dec_len [6] = '{2'd3,  2'd2,  2'd1,  2'd2,  2'd1,  2'd1};
   logic [15:0] dec_pc  [6] = '{16'h0001, 16'h0004, 16'h0006, 16'h0007, 16'h0009, 16'h000A};

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
      mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
      mem[16'h8000] = 8'hEA;
      mem[16'h8001] = 8'hA9; mem[16'h8002] = 8'h42;
      mem[16'h8003] = 8'h4C; mem[16'h8004] = 8'h34; mem[16'h8005] = 8'h12;
      mem[16'h8006] = 8'hA9; mem[16'h8007] = 8'h55;
      mem[16'hC000] = 8'hEA;
      mem[16'hFFFE] = 8'h8D; mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h20;
      mem[16'h0001] = 8'h20; mem[16'h0002] = 8'h11; mem[16'h0003] = 8'h22;
      mem[16'h0004] = 8'hA0; mem[16'h0005] = 8'h33;
      mem[16'h0006] = 8'h60;
      mem[16'h0007] = 8'h10; mem[16'h0008] = 8'h44;
      mem[16'h0009] = 8'h0A;
      mem[16'h000A] = 8'hFF;
      mem[16'h000B] = 8'hEA;
      mem[16'h000C] = 8'h4C; mem[16'h000D] = 8'h00; mem[16'h000E] = 8'h90;

      nrst = 1'b0; rdy = 1'b1; instr_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 16'h0000;
`ifdef FETCH_IRQ_INJECT_EN
      irq_n = 1'b1; irq_mask = 1'b0;
`endif
      @(negedge clk);
      @(negedge clk);
      chk("rst.addr",   32'(bus_addr),     32'hFFFC);
      chk("rst.rnw",    32'(bus_rnw),      32'd1);
      chk("rst.valid",  32'(instr_valid),  32'd0);
      chk("rst.opcode", 32'(instr_opcode), 32'd0);
      chk("rst.len",    32'(instr_len),    32'd0);
      chk("rst.pc",     32'(instr_pc),     32'd0);
`ifdef FETCH_IRQ_INJECT_EN
      chk("rst.irq",    32'(instr_irq),    32'd0);
`endif

      // Reset vector load, with a rdy stall in RST_LO
      rdy = 1'b0;
      nrst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("vec.stall", 32'(bus_addr), 32'hFFFC);
      rdy = 1'b1;
      @(negedge clk);
      chk("vec.hi", 32'(bus_addr), 32'hFFFD);
      @(negedge clk);
      chk("vec.pc", 32'(bus_addr), 32'h8000);
      wait_bundle("nop", 1, 8'hEA, 8'h00, 8'h00, 2'd1, 16'h8000);
      chk("nop.next", 32'(bus_addr), 32'h8001);

      // Back-pressure: bundle and bus frozen while instr_ready is low
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp.valid",  32'(instr_valid),  32'd1);
         chk("bp.opcode", 32'(instr_opcode), 32'hEA);
         chk("bp.addr",   32'(bus_addr),     32'h8001);
      end
      accept("nop");
      chk("nop.addr", 32'(bus_addr), 32'h8001);

      // LDA #imm with a 3-cycle rdy stall in OP1
      @(negedge clk);
      chk("lda.op1addr", 32'(bus_addr), 32'h8002);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("lda.stall", 32'(bus_addr),    32'h8002);
         chk("lda.inv",   32'(instr_valid), 32'd0);
      end
      rdy = 1'b1;
      wait_bundle("lda", 1, 8'hA9, 8'h42, 8'h00, 2'd2, 16'h8001);
      chk("lda.next", 32'(bus_addr), 32'h8003);
      accept("lda");

      wait_bundle("jmp", 3, 8'h4C, 8'h34, 8'h12, 2'd3, 16'h8003);
      chk("jmp.next", 32'(bus_addr), 32'h8006);
      accept("jmp");

      // Redirect during OP1 flushes the partial instruction
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 16'hC000;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("redir.addr",  32'(bus_addr),    32'hC000);
      chk("redir.valid", 32'(instr_valid), 32'd0);
      wait_bundle("redir", 1, 8'hEA, 8'h00, 8'h00, 2'd1, 16'hC000);

      // Redirect wins over a simultaneous handshake
      instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
      @(negedge clk);
      instr_ready = 1'b0; redirect_valid = 1'b0;
      chk("prio.addr",  32'(bus_addr),    32'hFFFE);
      chk("prio.valid", 32'(instr_valid), 32'd0);

      // PC wraps through FFFF to 0000
      @(negedge clk);
      chk("wrap.a1", 32'(bus_addr), 32'hFFFF);
      @(negedge clk);
      chk("wrap.a2", 32'(bus_addr), 32'h0000);
      wait_bundle("wrap", 1, 8'h8D, 8'h00, 8'h20, 2'd3, 16'hFFFE);
      chk("wrap.next", 32'(bus_addr), 32'h0001);
      accept("wrap");

      // Length decode across opcode classes
      for (int i = 0; i < 6; i++) begin
         wait_bundle("dec", int'(dec_len[i]), dec_op[i], dec_o1[i], dec_o2[i], dec_len[i], dec_pc[i]);
         accept("dec");
      end
      chk("dec.next", 32'(bus_addr), 32'h000B);

`ifdef FETCH_IRQ_INJECT_EN
      irq_n = 1'b0; irq_mask = 1'b0;
      @(negedge clk);
      chk("irq.valid",  32'(instr_valid),  32'd1);
      chk("irq.opcode", 32'(instr_opcode), 32'h00);
      chk("irq.len",    32'(instr_len),    32'd1);
      chk("irq.pc",     32'(instr_pc),     32'h000B);
      chk("irq.flag",   32'(instr_irq),    32'd1);
      chk("irq.addr",   32'(bus_addr),     32'h000B);
      irq_n = 1'b1;
      accept("irq");
      irq_n = 1'b0; irq_mask = 1'b1;
      wait_bundle("irqm", 1, 8'hEA, 8'h00, 8'h00, 2'd1, 16'h000B);
      chk("irqm.flag", 32'(instr_irq), 32'd0);
      irq_n = 1'b1; irq_mask = 1'b0;
      accept("irqm");
`else
      wait_bundle("plain", 1, 8'hEA, 8'h00, 8'h00, 2'd1, 16'h000B);
      accept("plain");
`endif

      // Asynchronous reset in the middle of an instruction
      @(negedge clk);
      chk("mid.op1", 32'(bus_addr), 32'h000D);
      nrst = 1'b0;
      #1;
      chk("mid.addr",   32'(bus_addr),     32'hFFFC);
      chk("mid.valid",  32'(instr_valid),  32'd0);
      chk("mid.opcode", 32'(instr_opcode), 32'd0);
      chk("mid.pc",     32'(instr_pc),     32'd0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      chk("re.hi", 32'(bus_addr), 32'hFFFD);
      @(negedge clk);
      chk("re.pc", 32'(bus_addr), 32'h8000);
      wait_bundle("re", 1, 8'hEA, 8'h00, 8'h00, 2'd1, 16'h8000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
